// File: rtl/calc_sequencer.sv
// calc_sequencer: key-driven sequencer for the BCD calculator datapath.
// Ports: clk, clear (sync reset), key_valid/key_code in, alu_bcd_out/alu_special
// in; bcd1/bcd2/op_selected to the ALU, display_bcd/display_neg, busy, state out.
// Build option: define CALC_CHAIN_EN to chain a non-negative result into A.
module calc_sequencer #(
  parameter int ALU_LATENCY = 2
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] alu_bcd_out,
  input  logic        alu_special,
  output logic [15:0] bcd1,
  output logic [15:0] bcd2,
  output logic [1:0]  op_selected,
  output logic [15:0] display_bcd,
  output logic        display_neg,
  output logic        busy,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    EXEC    = 2'b10,
    RESULT  = 2'b11
  } state_t;

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  state_t      st_q, st_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] res_q, res_d;
  logic        neg_q, neg_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  na_q, na_d;
  logic [2:0]  nb_q, nb_d;
  logic [3:0]  wt_q, wt_d;

  logic       is_dig;
  logic       is_op;
  logic       is_eq;
  logic       is_ac;
  logic [1:0] op_key;

  assign is_dig = key_valid && (key_code <= 4'd9);
  assign is_op  = key_valid &&
                  (key_code == 4'hA || key_code == 4'hB);
  assign is_eq  = key_valid && (key_code == 4'hE);
  assign is_ac  = key_valid && (key_code == 4'hF);
  assign op_key = (key_code == 4'hB) ? 2'b10 : 2'b01;

  always_comb begin
    st_d  = st_q;
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    neg_d = neg_q;
    op_d  = op_q;
    na_d  = na_q;
    nb_d  = nb_q;
    wt_d  = wt_q;
    if (is_ac) begin
      st_d  = ENTER_A;
      a_d   = '0;
      b_d   = '0;
      res_d = '0;
      neg_d = 1'b0;
      op_d  = 2'b00;
      na_d  = '0;
      nb_d  = '0;
      wt_d  = '0;
    end else begin
      unique case (st_q)
        ENTER_A: begin
          unique case (1'b1)
            is_dig: begin
              if (na_q < 3'd4) begin
                a_d  = {a_q[11:0], key_code};
                na_d = na_q + 3'd1;
              end
            end
            is_op: begin
              op_d = op_key;
              b_d  = '0;
              nb_d = '0;
              st_d = ENTER_B;
            end
            default: ;
          endcase
        end
        ENTER_B: begin
          unique case (1'b1)
            is_dig: begin
              if (nb_q < 3'd4) begin
                b_d  = {b_q[11:0], key_code};
                nb_d = nb_q + 3'd1;
              end
            end
            is_op: op_d = op_key;
            is_eq: begin
              wt_d = LAT;
              st_d = EXEC;
            end
            default: ;
          endcase
        end
        EXEC: begin
          wt_d = wt_q - 4'd1;
          // The ALU output is valid on the last cycle of the wait.
          if (wt_q == 4'd1) begin
            res_d = alu_bcd_out;
            neg_d = alu_special;
            st_d  = RESULT;
          end
        end
        RESULT: begin
          unique case (1'b1)
            is_dig: begin
              a_d  = {12'h000, key_code};
              na_d = 3'd1;
              b_d  = '0;
              nb_d = '0;
              op_d = 2'b00;
              st_d = ENTER_A;
            end
`ifdef CALC_CHAIN_EN
            is_op: begin
              // A negative result cannot be an unsigned BCD operand.
              if (!neg_q) begin
                a_d  = res_q;
                na_d = 3'd4;
                b_d  = '0;
                nb_d = '0;
                op_d = op_key;
                st_d = ENTER_B;
              end
            end
`endif
            default: ;
          endcase
        end
        default: st_d = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      st_q  <= ENTER_A;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      neg_q <= 1'b0;
      op_q  <= 2'b00;
      na_q  <= '0;
      nb_q  <= '0;
      wt_q  <= '0;
    end else begin
      st_q  <= st_d;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      neg_q <= neg_d;
      op_q  <= op_d;
      na_q  <= na_d;
      nb_q  <= nb_d;
      wt_q  <= wt_d;
    end
  end

  assign bcd1        = a_q;
  assign bcd2        = b_q;
  assign op_selected = op_q;
  assign state       = st_q;
  assign busy        = (st_q == EXEC);
  assign display_neg = (st_q == RESULT) && neg_q;

  always_comb begin
    display_bcd = b_q;
    unique case (st_q)
      ENTER_A: display_bcd = a_q;
      RESULT:  display_bcd = res_q;
      default: display_bcd = b_q;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: key-sequence vectors plus result scoreboard for
// calc_sequencer, driving a latency-accurate BCD ALU stand-in.
module tb_calc_sequencer;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] alu_bcd_out;
  logic        alu_special;
  logic [15:0] bcd1, bcd2, display_bcd;
  logic [1:0]  op_selected, state;
  logic        display_neg, busy;

  int checks = 0;
  int failures = 0;

  calc_sequencer #(.ALU_LATENCY(L)) dut (
    .clk(clk),
    .clear(clear),
    .key_valid(key_valid),
    .key_code(key_code),
    .alu_bcd_out(alu_bcd_out),
    .alu_special(alu_special),
    .bcd1(bcd1),
    .bcd2(bcd2),
    .op_selected(op_selected),
    .display_bcd(display_bcd),
    .display_neg(display_neg),
    .busy(busy),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic int b2i(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 +
           int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] i2b(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // ALU stand-in: the answer is only presented on the L-th EXEC cycle,
  // so any capture on the wrong cycle picks up the EEEE filler.
  int exec_cyc = 0;
  always @(posedge clk) exec_cyc <= busy ? exec_cyc + 1 : 0;

  always_comb begin
    int x;
    int m;
    x = (op_selected == 2'b10) ? b2i(bcd1) - b2i(bcd2)
                               : b2i(bcd1) + b2i(bcd2);
    m = (x < 0) ? -x : x;
    if (busy && exec_cyc == L - 1) begin
      alu_bcd_out = i2b(m);
      alu_special = (x < 0);
    end else begin
      alu_bcd_out = 16'hEEEE;
      alu_special = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  logic [16:0] sb[$];
  logic [1:0]  prev_st = 2'b00;

  always @(negedge clk) begin
    logic [16:0] e;
    if (state == 2'b11 && prev_st == 2'b10) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_capture act=%h exp=none", display_bcd);
      end else begin
        e = sb.pop_front();
        chk("result_bcd", 32'(display_bcd), 32'(e[15:0]));
        chk("result_neg", 32'(display_neg), 32'(e[16]));
      end
    end
    prev_st = state;
  end

  typedef struct {
    logic [31:0] keys;
    int          n;
    bit          push;
    logic [15:0] res;
    bit          rneg;
    logic [1:0]  st;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] disp;
    bit          neg;
  } vec_t;

  vec_t vt[15];

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] k;
    int bc;
    vt[0]  = '{32'hF12A34E0, 7, 1, 16'h0046, 0, 2'd3,
               16'h0012, 16'h0034, 2'b01, 16'h0046, 0};
`ifdef CALC_CHAIN_EN
    vt[1]  = '{32'hA4E00000, 3, 1, 16'h0050, 0, 2'd3,
               16'h0046, 16'h0004, 2'b01, 16'h0050, 0};
`else
    vt[1]  = '{32'hA4E00000, 3, 0, 16'h0000, 0, 2'd0,
               16'h0004, 16'h0000, 2'b00, 16'h0004, 0};
`endif
    vt[2]  = '{32'hF45B23E0, 7, 1, 16'h0022, 0, 2'd3,
               16'h0045, 16'h0023, 2'b10, 16'h0022, 0};
    vt[3]  = '{32'hF15B25E0, 7, 1, 16'h0010, 1, 2'd3,
               16'h0015, 16'h0025, 2'b10, 16'h0010, 1};
    vt[4]  = '{32'hA0000000, 1, 0, 16'h0000, 0, 2'd3,
               16'h0015, 16'h0025, 2'b10, 16'h0010, 1};
    vt[5]  = '{32'hF1234500, 6, 0, 16'h0000, 0, 2'd0,
               16'h1234, 16'h0000, 2'b00, 16'h1234, 0};
    vt[6]  = '{32'hB9999900, 6, 0, 16'h0000, 0, 2'd1,
               16'h1234, 16'h9999, 2'b10, 16'h9999, 0};
    vt[7]  = '{32'hE0000000, 1, 1, 16'h8765, 1, 2'd3,
               16'h1234, 16'h9999, 2'b10, 16'h8765, 1};
    vt[8]  = '{32'hF0001200, 6, 0, 16'h0000, 0, 2'd0,
               16'h0001, 16'h0000, 2'b00, 16'h0001, 0};
    vt[9]  = '{32'hFC7D0000, 4, 0, 16'h0000, 0, 2'd0,
               16'h0007, 16'h0000, 2'b00, 16'h0007, 0};
    vt[10] = '{32'hF3A5B000, 5, 0, 16'h0000, 0, 2'd1,
               16'h0003, 16'h0005, 2'b10, 16'h0005, 0};
    vt[11] = '{32'hE0000000, 1, 1, 16'h0002, 1, 2'd3,
               16'h0003, 16'h0005, 2'b10, 16'h0002, 1};
    vt[12] = '{32'h90000000, 1, 0, 16'h0000, 0, 2'd0,
               16'h0009, 16'h0000, 2'b00, 16'h0009, 0};
    vt[13] = '{32'hF7AE0000, 4, 1, 16'h0007, 0, 2'd3,
               16'h0007, 16'h0000, 2'b01, 16'h0007, 0};
    vt[14] = '{32'hF0000000, 1, 0, 16'h0000, 0, 2'd0,
               16'h0000, 16'h0000, 2'b00, 16'h0000, 0};

    clear = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_bcd1", 32'(bcd1), 32'd0);
    chk("rst_bcd2", 32'(bcd2), 32'd0);
    chk("rst_op", 32'(op_selected), 32'd0);
    chk("rst_disp", 32'(display_bcd), 32'd0);
    chk("rst_neg", 32'(display_neg), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    clear = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 15; v++) begin
      for (int i = 0; i < vt[v].n; i++) begin
        k = vt[v].keys[31 - 4 * i -: 4];
        if (k == 4'hE && vt[v].push)
          sb.push_back({vt[v].rneg, vt[v].res});
        press(k);
        if (k == 4'hE) wait_idle();
      end
      chk($sformatf("v%0d_state", v), 32'(state), 32'(vt[v].st));
      chk($sformatf("v%0d_bcd1", v), 32'(bcd1), 32'(vt[v].a));
      chk($sformatf("v%0d_bcd2", v), 32'(bcd2), 32'(vt[v].b));
      chk($sformatf("v%0d_op", v), 32'(op_selected), 32'(vt[v].op));
      chk($sformatf("v%0d_disp", v), 32'(display_bcd), 32'(vt[v].disp));
      chk($sformatf("v%0d_neg", v), 32'(display_neg), 32'(vt[v].neg));
    end

    // EXEC length, and a digit during EXEC must not disturb operands.
    press(4'hF); press(4'h1); press(4'h2);
    press(4'hA); press(4'h3); press(4'h4);
    sb.push_back({1'b0, 16'h0046});
    press(4'hE);
    bc = 0;
    if (busy) bc++;
    press(4'h7);
    for (int i = 0; i < 40 && busy; i++) begin
      bc++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(bc), 32'(L));
    chk("exec_bcd2_held", 32'(bcd2), 32'h0034);
    chk("exec_state_res", 32'(state), 32'd3);

    // All-clear on the first EXEC cycle aborts with no capture.
    press(4'hF); press(4'h1); press(4'h2);
    press(4'hA); press(4'h3); press(4'h4);
    press(4'hE);
    chk("abort_in_exec", 32'(state), 32'd2);
    press(4'hF);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_bcd1", 32'(bcd1), 32'd0);
    chk("abort_bcd2", 32'(bcd2), 32'd0);
    chk("abort_op", 32'(op_selected), 32'd0);
    chk("abort_disp", 32'(display_bcd), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (L + 3) @(negedge clk);
    chk("abort_stay", 32'(state), 32'd0);

    // clear together with a digit strobe: reset wins.
    press(4'h1); press(4'h2);
    chk("pre_clear_bcd1", 32'(bcd1), 32'h0012);
    clear = 1'b1;
    key_valid = 1'b1;
    key_code = 4'h3;
    @(negedge clk);
    clear = 1'b0;
    key_valid = 1'b0;
    chk("clr_key_bcd1", 32'(bcd1), 32'd0);
    chk("clr_key_state", 32'(state), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
